custom_regif_bridge: RTL and testbench
======================================

# custom_regif_bridge

APB-slave register bridge that sits directly upstream of the custom IP core. It turns 32-bit APB accesses into per-channel write requests on a level req/ack handshake toward the core (reg2ip side). It also captures the core's produced data (ip2reg side) into readable shadow registers. Three write channels, three read channels and one status register.

## Interface
- ADDR_W, 12, APB address width (byte address; bits [4:2] decode)
- TIMEOUT_CYC, 64, write-ack timeout in cycles (used only with timeout feature)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- paddr_i  in  ADDR_W  APB address
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data, registered
- pready_o  out  1  APB ready, registered
- pslverr_o  out  1  APB error, valid with pready_o
- reg2ip_data_o  out  96  write data, channel n at [32n+31:32n]
- reg2ip_en_o  out  3  write request per channel, level
- reg2ip_ack_i  in  3  write acknowledge per channel, level
- ip2reg_data_i  in  96  core result data, channel n at [32n+31:32n]
- ip2reg_valid_i  in  3  capture strobe per channel

## Operation
- Address map (word offsets):
  - 0x00/0x04/0x08: W0..W2, read/write; readback gives last written value.
  - 0x0C/0x10/0x14: R0..R2, read-only shadows.
  - 0x18: STATUS, read-only:
    - [2:0] Rn valid, sticky
    - [5:3] reg2ip_en_o mirror
    - [8] timeout sticky
  - STATUS read clears bit 8.
- Any other offset, or a write to R0..R2/STATUS: error response (pslverr_o=1), no side effects.
- FSM states IDLE, WR_REQ, RESP.
  - IDLE, psel_i & penable_i, mapped read: load prdata_o → RESP.
  - IDLE, write to Wn: latch pwdata_i into channel-n data slice, set reg2ip_en_o[n] → WR_REQ.
  - IDLE, error access: → RESP with pslverr.
  - WR_REQ: reg2ip_ack_i[n]=1 sampled → clear reg2ip_en_o[n] → RESP.
  - RESP: pready_o=1 for exactly one cycle → IDLE.
- Only one channel request is outstanding at a time. The APB stalls for the whole handshake.
- If ack is already high when the request is raised, the write completes on the first WR_REQ cycle.
- Capture: ip2reg_valid_i[n]=1 at a clock edge loads the channel-n shadow from ip2reg_data_i and sets STATUS[n].
- Reading Rn clears STATUS[n]. If a capture and a clear land on the same edge, the set wins.
- A read of Rn on the same edge as a capture returns the pre-capture value.
- Reset values: all outputs 0; W and R shadows 0; STATUS 0; FSM IDLE.
- An asynchronous reset mid-handshake drops reg2ip_en_o and pready_o immediately.

## Timing
- k = first cycle psel_i & penable_i are seen in IDLE.
- Read and error accesses: pready_o=1 at k+1 (one wait state).
- Write:
  - reg2ip_en_o[n] rises at k+1.
  - Ack sampled at cycle j ≥ k+1.
  - reg2ip_en_o[n] falls and pready_o=1 at j+1.
  - Minimum latency is 2 cycles.
- reg2ip_data_o slice is stable from k+1 until the next write to that channel.
- Capture latency: shadow and STATUS visible 1 cycle after the strobe.

## Configuration
- Macro CUSTOM_REGIF_TIMEOUT_EN.
- Defined: a counter runs in WR_REQ. After TIMEOUT_CYC cycles without ack:
  - reg2ip_en_o[n] is dropped;
  - RESP with pslverr_o=1;
  - STATUS[8] is set.
  - Total write latency on timeout is TIMEOUT_CYC+1 cycles.
- Undefined: WR_REQ waits indefinitely, STATUS[8] reads 0, no counter logic.

## Structure
- Package custom_regif_pkg:
  - NUM_CH=3 and DATA_W=32;
  - address offset localparams;
  - FSM state enum (IDLE, WR_REQ, RESP).
- One sub-module is natural: custom_regif_shadow, a per-channel capture register plus sticky valid bit with set-over-clear. It is instantiated NUM_CH times.

## Test plan
- Write 0x2468 to 0x04, ack tied high → reg2ip_en_o=3'b010 for one cycle, slice1=0x2468, pready at k+2, readback 0x2468.
- Write to 0x00, ack asserted 5 cycles after the request → pready at request+6; en falls the same cycle; pslverr=0.
- ip2reg_valid_i=3'b100 with data 0x48D0 → read 0x14 returns 0x48D0, STATUS[2] set then cleared by the read; simultaneous capture and read → old value returned, valid stays 1.
- Read 0x1C and write 0x0C → pslverr_o=1 at k+1, no state change.
- With CUSTOM_REGIF_TIMEOUT_EN and TIMEOUT_CYC=8, ack held low → pslverr at k+9, STATUS[8]=1, cleared after the STATUS read.
- Assert rst_ni low during WR_REQ → reg2ip_en_o and pready_o drop asynchronously; all registers read 0 after release.

Source files
------------

// File: rtl/custom_regif_pkg.sv
// Shared constants for the APB register bridge: channel geometry, register map, FSM states.
package custom_regif_pkg;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;

  // Register word index = byte offset >> 2
  localparam logic [2:0] IDX_W0     = 3'd0;
  localparam logic [2:0] IDX_W1     = 3'd1;
  localparam logic [2:0] IDX_W2     = 3'd2;
  localparam logic [2:0] IDX_R0     = 3'd3;
  localparam logic [2:0] IDX_R1     = 3'd4;
  localparam logic [2:0] IDX_R2     = 3'd5;
  localparam logic [2:0] IDX_STATUS = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/custom_regif_shadow.sv
// One ip2reg capture register with a sticky valid flag; a capture beats a same-edge clear.
module custom_regif_shadow
  import custom_regif_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] cap_data_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = cap_i ? cap_data_i : data_q;
    valid_d = cap_i | (valid_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/custom_regif_bridge.sv
// APB slave turning register writes into level req/ack requests toward the core, plus ip2reg shadows.
// Optional write-ack timeout is compiled in with `define CUSTOM_REGIF_TIMEOUT_EN.
module custom_regif_bridge
  import custom_regif_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDR_W-1:0]        paddr_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [DATA_W-1:0]        pwdata_i,
  output logic [DATA_W-1:0]        prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  output logic [NUM_CH*DATA_W-1:0] reg2ip_data_o,
  output logic [NUM_CH-1:0]        reg2ip_en_o,
  input  logic [NUM_CH-1:0]        reg2ip_ack_i,
  input  logic [NUM_CH*DATA_W-1:0] ip2reg_data_i,
  input  logic [NUM_CH-1:0]        ip2reg_valid_i
);

  // APB handshake: an access is taken when psel_i & penable_i are seen in IDLE; the master
  // holds all APB inputs stable until it observes pready_o=1, which lasts exactly one cycle.
  state_e                     state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic [1:0]                 ch_q, ch_d;
  logic [DATA_W-1:0]          prdata_q, prdata_d;
  logic                       pready_q, pready_d;
  logic                       pslverr_q, pslverr_d;

  logic [NUM_CH-1:0]          rd_clr;
  logic [NUM_CH*DATA_W-1:0]   shadow_data;
  logic [NUM_CH-1:0]          shadow_valid;
  logic                       to_fire;
  logic                       to_sticky;
  logic                       ack_hit;

  logic                       access;
  logic                       in_range;
  logic [2:0]                 idx;
  logic                       wr_ok;
  logic                       rd_ok;
  logic [DATA_W-1:0]          rd_word;
  logic [DATA_W-1:0]          status_word;

  assign access   = psel_i & penable_i;
  assign idx      = paddr_i[4:2];
  assign in_range = (paddr_i[ADDR_W-1:5] == '0) && (paddr_i[1:0] == 2'b00) && (idx <= IDX_STATUS);
  assign wr_ok    = in_range & pwrite_i & (idx <= IDX_W2);
  assign rd_ok    = in_range & ~pwrite_i;
  assign ack_hit  = reg2ip_ack_i[ch_q];

  assign status_word = {23'd0, to_sticky, 2'b00, en_q, shadow_valid};

  always_comb begin
    rd_word = '0;
    case (idx)
      IDX_W0:     rd_word = wdata_q[0 +: DATA_W];
      IDX_W1:     rd_word = wdata_q[DATA_W +: DATA_W];
      IDX_W2:     rd_word = wdata_q[2*DATA_W +: DATA_W];
      IDX_R0:     rd_word = shadow_data[0 +: DATA_W];
      IDX_R1:     rd_word = shadow_data[DATA_W +: DATA_W];
      IDX_R2:     rd_word = shadow_data[2*DATA_W +: DATA_W];
      IDX_STATUS: rd_word = status_word;
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    en_d      = en_q;
    ch_d      = ch_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    rd_clr    = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (wr_ok) begin
            ch_d = idx[1:0];
            for (int n = 0; n < NUM_CH; n++) begin
              if (idx == 3'(n)) begin
                wdata_d[n*DATA_W +: DATA_W] = pwdata_i;
                en_d[n]                     = 1'b1;
              end
            end
            state_d = WR_REQ;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = ~rd_ok;
            if (rd_ok) begin
              prdata_d = rd_word;
              for (int n = 0; n < NUM_CH; n++) begin
                if (idx == IDX_R0 + 3'(n)) rd_clr[n] = 1'b1;
              end
            end
          end
        end
      end
      WR_REQ: begin
        // Ack has priority over a timeout landing on the same cycle
        if (ack_hit) begin
          en_d     = '0;
          state_d  = RESP;
          pready_d = 1'b1;
        end else if (to_fire) begin
          en_d      = '0;
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wdata_q   <= '0;
      en_q      <= '0;
      ch_q      <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      en_q      <= en_d;
      ch_q      <= ch_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

`ifdef CUSTOM_REGIF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             to_clr;

  // Counter is zero on the first WR_REQ cycle, so it fires after TIMEOUT_CYC ack-less cycles
  assign to_fire = (state_q == WR_REQ) && !ack_hit && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign to_clr  = (state_q == IDLE) && access && rd_ok && (idx == IDX_STATUS);

  always_comb begin
    cnt_d = '0;
    if (state_q == WR_REQ && !ack_hit) cnt_d = cnt_q + 1'b1;
    to_d = to_fire | (to_q & ~to_clr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign to_sticky = to_q;
`else
  assign to_fire   = 1'b0;
  assign to_sticky = 1'b0;
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_shadow
    custom_regif_shadow u_shadow (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cap_i      (ip2reg_valid_i[n]),
      .cap_data_i (ip2reg_data_i[n*DATA_W +: DATA_W]),
      .clr_i      (rd_clr[n]),
      .data_o     (shadow_data[n*DATA_W +: DATA_W]),
      .valid_o    (shadow_valid[n])
    );
  end

  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign pslverr_o     = pslverr_q;
  assign reg2ip_data_o = wdata_q;
  assign reg2ip_en_o   = en_q;

endmodule

// File: tb/tb_custom_regif_bridge.sv
// Directed + randomized bench for custom_regif_bridge against a register-level reference model.
module tb_custom_regif_bridge;

  localparam int TO_CYC = 8;
  localparam int BUDGET = 200;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [11:0] paddr_i = '0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [31:0] pwdata_i = '0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic [95:0] reg2ip_data_o;
  logic [2:0]  reg2ip_en_o;
  logic [2:0]  reg2ip_ack_i = '0;
  logic [95:0] ip2reg_data_i = '0;
  logic [2:0]  ip2reg_valid_i = '0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  custom_regif_bridge #(.ADDR_W(12), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .paddr_i        (paddr_i),
    .psel_i         (psel_i),
    .penable_i      (penable_i),
    .pwrite_i       (pwrite_i),
    .pwdata_i       (pwdata_i),
    .prdata_o       (prdata_o),
    .pready_o       (pready_o),
    .pslverr_o      (pslverr_o),
    .reg2ip_data_o  (reg2ip_data_o),
    .reg2ip_en_o    (reg2ip_en_o),
    .reg2ip_ack_i   (reg2ip_ack_i),
    .ip2reg_data_i  (ip2reg_data_i),
    .ip2reg_valid_i (ip2reg_valid_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: register contents as software sees them
  logic [31:0] w_mdl [3];
  logic [31:0] r_mdl [3];
  logic [2:0]  v_mdl;
  logic        to_mdl;
  logic [31:0] exp_q [$];

  // ack responder: 0 = ack after ack_delay request cycles, 1 = tied high, 2 = never
  int ack_mode  = 0;
  int ack_delay = 0;

  initial begin : ack_responder
    int cnt [3];
    for (int n = 0; n < 3; n++) cnt[n] = 0;
    forever begin
      @(posedge clk_i); #1;
      for (int n = 0; n < 3; n++) begin
        cnt[n] = reg2ip_en_o[n] ? cnt[n] + 1 : 0;
        case (ack_mode)
          1:       reg2ip_ack_i[n] = 1'b1;
          2:       reg2ip_ack_i[n] = 1'b0;
          default: reg2ip_ack_i[n] = reg2ip_en_o[n] && (cnt[n] > ack_delay);
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input int idx);
    case (idx)
      0, 1, 2: return w_mdl[idx];
      3, 4, 5: return r_mdl[idx-3];
      6:       return {23'd0, to_mdl, 5'd0, v_mdl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic mdl_cap(input logic [2:0] v, input logic [95:0] d);
    for (int n = 0; n < 3; n++) begin
      if (v[n]) begin
        r_mdl[n] = d[n*32 +: 32];
        v_mdl[n] = 1'b1;
      end
    end
  endtask

  task automatic mdl_reset();
    for (int n = 0; n < 3; n++) begin
      w_mdl[n] = '0;
      r_mdl[n] = '0;
    end
    v_mdl  = '0;
    to_mdl = 1'b0;
  endtask

  // driver: one APB transfer; cap_v/cap_d are strobed on the access cycle
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [2:0] cap_v, input logic [95:0] cap_d,
                     output int lat, output logic [31:0] rdata, output logic err,
                     output logic [2:0] en_or, output int en_cnt);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
    @(posedge clk_i); #1;
    penable_i = 1'b1; ip2reg_valid_i = cap_v; ip2reg_data_i = cap_d;
    lat = 0; en_or = '0; en_cnt = 0;
    do begin
      @(posedge clk_i); #1;
      ip2reg_valid_i = '0;
      lat++;
      en_or = en_or | reg2ip_en_o;
      if (reg2ip_en_o != 3'b000) en_cnt++;
    end while (!pready_o && lat < BUDGET);
    rdata = prdata_o; err = pslverr_o;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic do_write(input int ch, input logic [31:0] d, input int mode, input int dly,
                          input logic [2:0] cap_v, input logic [95:0] cap_d);
    int lat, en_cnt, exp_lat;
    logic [31:0] rdata;
    logic err;
    logic [2:0] en_or;
    ack_mode = mode; ack_delay = dly;
    exp_lat = (mode == 1) ? 2 : dly + 2;
    apb(1'b1, 12'(ch * 4), d, cap_v, cap_d, lat, rdata, err, en_or, en_cnt);
    chk("wr_latency", 32'(lat), 32'(exp_lat));
    chk("wr_pslverr", {31'd0, err}, 32'd0);
    chk("wr_en_chan", {29'd0, en_or}, 32'(1 << ch));
    chk("wr_en_cycles", 32'(en_cnt), 32'(exp_lat - 1));
    chk("wr_en_fall", {29'd0, reg2ip_en_o}, 32'd0);
    chk("wr_slice", reg2ip_data_o[ch*32 +: 32], d);
    w_mdl[ch] = d;
    mdl_cap(cap_v, cap_d);
  endtask

  task automatic do_read(input int idx, input logic [2:0] cap_v, input logic [95:0] cap_d);
    int lat, en_cnt;
    logic [31:0] rdata;
    logic err;
    logic [2:0] en_or;
    exp_q.push_back(mdl_read(idx));
    apb(1'b0, 12'(idx * 4), 32'd0, cap_v, cap_d, lat, rdata, err, en_or, en_cnt);
    chk("rd_latency", 32'(lat), 32'd1);
    chk("rd_pslverr", {31'd0, err}, 32'd0);
    chk("rd_data", rdata, exp_q.pop_front());
    if (idx >= 3 && idx <= 5) v_mdl[idx-3] = 1'b0;
    if (idx == 6) to_mdl = 1'b0;
    mdl_cap(cap_v, cap_d);
  endtask

  task automatic do_err(input logic wr, input int idx, input logic [2:0] cap_v, input logic [95:0] cap_d);
    int lat, en_cnt;
    logic [31:0] rdata;
    logic err;
    logic [2:0] en_or;
    apb(wr, 12'(idx * 4), $urandom, cap_v, cap_d, lat, rdata, err, en_or, en_cnt);
    chk("err_latency", 32'(lat), 32'd1);
    chk("err_pslverr", {31'd0, err}, 32'd1);
    chk("err_no_req", {29'd0, en_or}, 32'd0);
    mdl_cap(cap_v, cap_d);
  endtask

  task automatic capture(input logic [2:0] v, input logic [95:0] d);
    ip2reg_valid_i = v; ip2reg_data_i = d;
    @(posedge clk_i); #1;
    ip2reg_valid_i = '0;
    mdl_cap(v, d);
  endtask

  initial begin : main
    logic [95:0] cd;
    logic [2:0]  cv;
    int op;
    mdl_reset();

    // reset state
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_prdata", prdata_o, 32'd0);
    chk("rst_pready", {31'd0, pready_o}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr_o}, 32'd0);
    chk("rst_en", {29'd0, reg2ip_en_o}, 32'd0);
    chk("rst_data_hi", reg2ip_data_o[95:64], 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // write W1 with ack tied high, then read it back
    ack_mode = 1;
    @(posedge clk_i); #1;
    do_write(1, 32'h0000_2468, 1, 0, 3'b000, 96'd0);
    do_read(1, 3'b000, 96'd0);

    // write W0 with ack 5 cycles after the request
    do_write(0, 32'hCAFE_0001, 0, 5, 3'b000, 96'd0);
    do_read(0, 3'b000, 96'd0);

    // capture on channel 2, STATUS set then cleared by reading R2
    capture(3'b100, {32'h0000_48D0, 64'd0});
    do_read(6, 3'b000, 96'd0);
    do_read(5, 3'b000, 96'd0);
    do_read(6, 3'b000, 96'd0);

    // capture on the same edge as the R2 read: old value returned, valid stays set
    capture(3'b100, {32'h0000_1357, 64'd0});
    do_read(5, 3'b100, {32'h0000_ABCD, 64'd0});
    do_read(6, 3'b000, 96'd0);
    do_read(5, 3'b000, 96'd0);

    // error accesses leave state untouched
    capture(3'b001, {64'd0, 32'h5555_AAAA});
    do_err(1'b0, 7, 3'b000, 96'd0);
    do_err(1'b1, 3, 3'b000, 96'd0);
    do_err(1'b1, 6, 3'b000, 96'd0);
    do_read(3, 3'b000, 96'd0);
    do_read(0, 3'b000, 96'd0);

`ifdef CUSTOM_REGIF_TIMEOUT_EN
    // timeout: ack never arrives
    begin
      int lat, en_cnt;
      logic [31:0] rdata;
      logic err;
      logic [2:0] en_or;
      ack_mode = 2;
      apb(1'b1, 12'h008, 32'hDEAD_BEEF, 3'b000, 96'd0, lat, rdata, err, en_or, en_cnt);
      chk("to_latency", 32'(lat), 32'(TO_CYC + 1));
      chk("to_pslverr", {31'd0, err}, 32'd1);
      chk("to_en_cycles", 32'(en_cnt), 32'(TO_CYC));
      chk("to_en_fall", {29'd0, reg2ip_en_o}, 32'd0);
      w_mdl[2] = 32'hDEAD_BEEF;
      to_mdl = 1'b1;
      ack_mode = 0;
      do_read(6, 3'b000, 96'd0);
      do_read(6, 3'b000, 96'd0);
    end
`endif

    // randomized mix against the model
    for (int i = 0; i < 60; i++) begin
      cv = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cd = {$urandom, $urandom, $urandom};
      op = $urandom_range(0, 9);
      if (op <= 3)
        do_write($urandom_range(0, 2), $urandom, $urandom_range(0, 1), $urandom_range(0, 4), cv, cd);
      else if (op <= 7)
        do_read($urandom_range(0, 6), cv, cd);
      else if (op == 8)
        do_err(1'b0, 7, cv, cd);
      else
        do_err(1'b1, $urandom_range(3, 7), cv, cd);
    end

    // asynchronous reset in the middle of a write handshake
    ack_mode = 2;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 12'h004; pwdata_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("mid_en_high", {29'd0, reg2ip_en_o}, 32'd2);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_en_drop", {29'd0, reg2ip_en_o}, 32'd0);
    chk("async_pready_drop", {31'd0, pready_o}, 32'd0);
    chk("async_data_clear", reg2ip_data_o[63:32], 32'd0);
    psel_i = 1'b0; penable_i = 1'b0;
    ack_mode = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    mdl_reset();
    @(posedge clk_i); #1;
    for (int idx = 0; idx < 7; idx++) do_read(idx, 3'b000, 96'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
